bitrev_addr_seq: RTL and testbench
==================================

// Module: bitrev_addr_seq
// PURPOSE
//  Runtime-configurable FFT address sequencer. Emits 2^L addresses, natural or
//  bit-reversed order, over a valid/ready stream. Drives the ping-pong bank
//  reorder write and the sample load/unload paths.
//  Fully synchronous to clk; no sequence table in memory.
//  Transform length is selected per run: L = log2n, 1 <= L <= MAX_LOG2N.
// PARAMETERS
//  MAX_LOG2N  10  log2 of largest supported transform; sets address width
//  LW         4   width of log2n port; must hold MAX_LOG2N (>= clog2(MAX_LOG2N+1))
// PORTS
//  clk        in   1            clock, all logic on posedge
//  rst_n      in   1            asynchronous, active-low reset
//  start      in   1            run request, sampled in IDLE only
//  log2n      in   LW           transform size L for this run, sampled with start
//  mode       in   1            0 = natural order, 1 = bit-reversed order, sampled with start
//  abort      in   1            synchronous cancel of a run in progress
//  ready      in   1            downstream accepts current address
//  addr_valid out  1            addr/addr_idx/last are valid
//  addr       out  MAX_LOG2N    output address; bits [MAX_LOG2N-1:L] always 0
//  addr_idx   out  MAX_LOG2N+1  natural index k of current address (0..2^L-1)
//  last       out  1            current address is final of run (k = 2^L-1)
//  busy       out  1            high in RUN
//  done       out  1            one-cycle pulse after final handshake
//  cfg_err    out  1            one-cycle pulse on start with illegal log2n
// BEHAVIOUR
//  Reset (rst_n low, asynchronous): state IDLE.
//   All outputs 0: addr_valid, addr, addr_idx, last, busy, done, cfg_err.
//  States: IDLE, RUN, DONE.
//  IDLE:
//   - start=1 and 1<=log2n<=MAX_LOG2N: latch L and mode, k=0, go RUN.
//   - start=1 and log2n==0 or log2n>MAX_LOG2N: cfg_err=1 for one cycle, stay IDLE.
//  RUN:
//   - Outputs registered. addr_valid=1 and busy=1 from the first RUN cycle.
//   - First address appears the cycle after start is sampled.
//   - Handshake: transfer on addr_valid && ready, one address per cycle max.
//   - With ready stuck high: 2^L consecutive valid cycles.
//   - addr/addr_idx/last hold stable while addr_valid && !ready.
//   - mode=0: addr = k.
//   - mode=1: addr[b] = k[L-1-b] for b<L; addr[b] = 0 for b>=L.
//   - last = (k == 2^L-1). addr_idx = k, zero-extended.
//   - Transfer with last=1: go DONE, addr_valid=0, busy=0.
//   - start ignored in RUN and DONE; log2n and mode changes ignored until next IDLE start.
//  DONE: done=1 for exactly one cycle, then IDLE. Earliest restart is the cycle after DONE.
//  abort=1 in RUN: next cycle IDLE, addr_valid/busy/last=0, no done pulse.
//   - abort has priority over a same-cycle transfer, including the final one.
//   - abort in IDLE or DONE has no effect; a DONE pulse in progress still completes.
//  L=1: sequence is 0,1 in both modes.
//   - For any L, first and final addresses equal 0 and 2^L-1 in both modes.
//  addr_idx counter is MAX_LOG2N+1 bits; it never wraps inside a run.
//  No combinational path from ready/start/abort to any output.
// TESTING
//  1. L=3, mode=1, ready=1 -> addr 0,4,2,6,1,5,3,7.
//     last on 7; done one cycle after last transfer.
//  2. L=3, mode=0, ready toggles 1,0 -> addr 0..7 in order.
//     Each value held through stall cycles; exactly 8 transfers.
//  3. L=MAX_LOG2N=10, mode=1 -> k=1 gives 512, k=2 gives 256, k=1023 gives 1023.
//     1024 transfers, then done.
//  4. log2n=0 and log2n=11 with start -> cfg_err pulse, busy stays 0, no addr_valid.
//  5. Run L=4; abort at k=5 -> IDLE next cycle, no done.
//     Restart L=2, mode=1 -> addr 0,2,1,3.
//  6. rst_n low mid-run at k=3 -> all outputs 0 immediately.
//     Start after release -> sequence restarts at k=0.

Source files
------------

// File: rtl/bitrev_addr_seq.sv
// FFT address sequencer: emits 2^L indices in natural or bit-reversed order over a
// valid/ready stream. Length and order are latched per run.
module bitrev_addr_seq #(
  parameter int MAX_LOG2N = 10,
  parameter int LW        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LW-1:0]        log2n,
  input  logic                 mode,
  input  logic                 abort,
  input  logic                 ready,
  output logic                 addr_valid,
  output logic [MAX_LOG2N-1:0] addr,
  output logic [MAX_LOG2N:0]   addr_idx,
  output logic                 last,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  localparam int AW = MAX_LOG2N;
  localparam int KW = MAX_LOG2N + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_state_nx;
  logic [LW-1:0] r_len, w_len_nx;
  logic          r_mode, w_mode_nx;
  logic [KW-1:0] r_k, w_k_nx;
  logic          w_cfg_ok, w_done_nx, w_cfg_err_nx, w_run_nx;
  logic [AW-1:0] w_addr_nx;

  function automatic logic [KW-1:0] f_kmax(input logic [LW-1:0] len);
    return (KW'(1) << len) - KW'(1);
  endfunction

  // Full-width reversal then right shift leaves k[L-1-b] in bit b and zeros above L.
  function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] k, input logic [LW-1:0] len);
    logic [AW-1:0] rev;
    for (int b = 0; b < AW; b++) rev[b] = k[AW-1-b];
    return rev >> (AW - int'(len));
  endfunction

  assign w_cfg_ok = (log2n != '0) && (log2n <= LW'(MAX_LOG2N));

  always_comb begin
    w_state_nx   = r_state;
    w_len_nx     = r_len;
    w_mode_nx    = r_mode;
    w_k_nx       = r_k;
    w_done_nx    = 1'b0;
    w_cfg_err_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_cfg_ok) begin
            w_state_nx = S_RUN;
            w_len_nx   = log2n;
            w_mode_nx  = mode;
            w_k_nx     = '0;
          end else begin
            w_cfg_err_nx = 1'b1;
          end
        end
      end
      S_RUN: begin
        // abort wins over a same-cycle transfer, including the final one
        if (abort) begin
          w_state_nx = S_IDLE;
        end else if (ready) begin
          if (r_k == f_kmax(r_len)) begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
          end else begin
            w_k_nx = r_k + KW'(1);
          end
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_run_nx  = (w_state_nx == S_RUN);
  assign w_addr_nx = w_mode_nx ? f_bitrev(w_k_nx[AW-1:0], w_len_nx) : w_k_nx[AW-1:0];

  // Outputs are registered from next-state values so they appear with the state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_mode     <= 1'b0;
      r_k        <= '0;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      last       <= 1'b0;
      addr       <= '0;
      addr_idx   <= '0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_len      <= w_len_nx;
      r_mode     <= w_mode_nx;
      r_k        <= w_k_nx;
      addr_valid <= w_run_nx;
      busy       <= w_run_nx;
      last       <= w_run_nx && (w_k_nx == f_kmax(w_len_nx));
      addr       <= w_run_nx ? w_addr_nx : '0;
      addr_idx   <= w_run_nx ? w_k_nx : '0;
      done       <= w_done_nx;
      cfg_err    <= w_cfg_err_nx;
    end
  end

endmodule

// File: tb/tb_bitrev_addr_seq.sv
// Scoreboard bench for bitrev_addr_seq: expected addresses queued at run start,
// popped on each observed handshake.
module tb_bitrev_addr_seq;
  localparam int MAXL = 10;
  localparam int LW   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [LW-1:0]   log2n = '0;
  logic            mode = 1'b0;
  logic            abort = 1'b0;
  logic            ready = 1'b0;
  logic            addr_valid;
  logic [MAXL-1:0] addr;
  logic [MAXL:0]   addr_idx;
  logic            last, busy, done, cfg_err;

  bitrev_addr_seq #(.MAX_LOG2N(MAXL), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .log2n(log2n), .mode(mode),
    .abort(abort), .ready(ready), .addr_valid(addr_valid), .addr(addr),
    .addr_idx(addr_idx), .last(last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int k; int l; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int done_due = 0;
  bit stall_f = 0;
  int held_a, held_k;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_addr(input int k, input int l, input int md);
    int r = 0;
    if (md == 0) return k;
    for (int b = 0; b < l; b++) if (k & (1 << (l - 1 - b))) r |= (1 << b);
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      done_due = 0;
      stall_f  = 0;
    end else begin
      if (stall_f && addr_valid) begin
        chk("hold_addr", int'(addr), held_a);
        chk("hold_idx", int'(addr_idx), held_k);
      end
      stall_f = addr_valid && !ready && !abort;
      held_a  = int'(addr);
      held_k  = int'(addr_idx);
      if (done_due == 1) begin
        chk("done_pulse", int'(done), 1);
        chk("valid_after_last", int'(addr_valid), 0);
        done_due = 2;
      end else if (done_due == 2) begin
        chk("done_width", int'(done), 0);
        done_due = 0;
      end else if (done) begin
        chk("done_spurious", int'(done), 0);
      end
      if (done) done_cnt++;
      if (addr_valid && ready && !abort) begin
        xfer_cnt++;
        if (q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = q.pop_front();
          chk("addr", int'(addr), e.a);
          chk("idx", int'(addr_idx), e.k);
          chk("last", int'(last), e.l);
          if (e.l != 0) done_due = 1;
        end
      end
    end
  end

  task automatic push_run(input int l, input int md, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.a = ref_addr(k, l, md);
      e.k = k;
      e.l = (k == (1 << l) - 1) ? 1 : 0;
      q.push_back(e);
    end
  endtask

  // pat: 0 = ready high, 1 = toggling 1,0, 2 = random
  task automatic run(input int l, input int md, input int pat);
    int xbase = xfer_cnt;
    int dbase = done_cnt;
    int cyc;
    push_run(l, md, 1 << l);
    log2n = LW'(l);
    mode  = md[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    log2n = LW'(1);
    mode  = ~md[0];
    chk("busy_first", int'(busy), 1);
    chk("valid_first", int'(addr_valid), 1);
    for (cyc = 0; cyc < 8000 && done_cnt == dbase; cyc++) begin
      if (pat == 0) ready = 1'b1;
      else if (pat == 1) ready = (cyc % 2 == 0);
      else ready = 1'($urandom_range(0, 1));
      if (cyc > 0) start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (done_cnt == dbase) chk("run_timeout", 0, 1);
    ready = 1'b0;
    chk("xfer_count", xfer_cnt - xbase, 1 << l);
    chk("sb_empty", q.size(), 0);
    tick();
  endtask

  task automatic bad_cfg(input int l);
    log2n = LW'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg_err_pulse", int'(cfg_err), 1);
    chk("cfg_busy", int'(busy), 0);
    chk("cfg_valid", int'(addr_valid), 0);
    tick();
    chk("cfg_err_width", int'(cfg_err), 0);
    chk("cfg_valid_after", int'(addr_valid), 0);
  endtask

  initial begin
    int dbase, xbase, n;
    tick();
    tick();
    chk("reset_outputs", int'({addr_valid, addr, addr_idx, last, busy, done, cfg_err}), 0);
    rst_n = 1'b1;
    tick();

    run(3, 1, 0);
    run(3, 0, 1);
    run(10, 1, 2);
    run(1, 0, 0);
    run(1, 1, 1);

    bad_cfg(0);
    bad_cfg(11);
    bad_cfg(15);

    // abort at k=5 of an L=4 run
    dbase = done_cnt;
    xbase = xfer_cnt;
    push_run(4, 0, 5);
    log2n = LW'(4);
    mode  = 1'b0;
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (int'(addr_idx) != 5 && n < 50) begin
      tick();
      n++;
    end
    chk("abort_reach_k5", int'(addr_idx), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ready = 1'b0;
    chk("abort_valid", int'(addr_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_last", int'(last), 0);
    tick();
    tick();
    chk("abort_no_done", done_cnt - dbase, 0);
    chk("abort_xfers", xfer_cnt - xbase, 5);
    chk("abort_sb_empty", q.size(), 0);
    run(2, 1, 0);

    // asynchronous reset mid-run at k=3
    push_run(3, 0, 8);
    log2n = LW'(3);
    mode  = 1'b0;
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (int'(addr_idx) != 3 && n < 50) begin
      tick();
      n++;
    end
    chk("rst_reach_k3", int'(addr_idx), 3);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", int'({addr_valid, addr, addr_idx, last, busy, done, cfg_err}), 0);
    ready = 1'b0;
    q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run(3, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
